// File: rtl/rv_iopmp_err_reader.sv
// IOPMP error-capture reader: on wsi, reads ERR_INFO/REQID/REQADDR/REQADDRH, clears ERR_INFO.v and queues a record.
// Optional RV_IOPMP_ERR_READER_TIMESTAMP_EN adds a free-running cycle stamp per record (rec_ts_o).
package rv_iopmp_err_reader_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module rv_iopmp_err_reader #(
    parameter type         reg_req_t       = rv_iopmp_err_reader_pkg::reg_req_t,
    parameter type         reg_rsp_t       = rv_iopmp_err_reader_pkg::reg_rsp_t,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter logic [31:0] OFF_ERR_INFO    = 32'h60,
    parameter logic [31:0] OFF_ERR_REQID   = 32'h64,
    parameter logic [31:0] OFF_ERR_REQADDR = 32'h68,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned HOLDOFF         = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wsi_i,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i,
    output logic        rec_valid_o,
    input  logic        rec_ready_i,
    output logic [31:0] rec_info_o,
    output logic [31:0] rec_reqid_o,
    output logic [63:0] rec_addr_o,
`ifdef RV_IOPMP_ERR_READER_TIMESTAMP_EN
    output logic [31:0] rec_ts_o,
`endif
    output logic        bus_err_o,
    output logic [15:0] drop_cnt_o
);

    typedef enum logic [2:0] {IDLE, RD_INFO, RD_ID, RD_LO, RD_HI, CLEAR, HOLD} state_e;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
`ifdef RV_IOPMP_ERR_READER_TIMESTAMP_EN
    localparam int RW = 160;
`else
    localparam int RW = 128;
`endif

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q;
    logic [31:0]   info_q, id_q, lo_q, hi_q;
    logic [15:0]   drop_q;
    logic          bus_err_q;
    logic          in_access;
    logic          push, pop;

    logic [RW-1:0] mem [FIFO_DEPTH];
    logic [RW-1:0] rec_d, head;
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;

`ifdef RV_IOPMP_ERR_READER_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, ts_stage_q;
    assign rec_d = {ts_stage_q, info_q, id_q, hi_q, lo_q};
`else
    assign rec_d = {info_q, id_q, hi_q, lo_q};
`endif

    assign in_access = (state_q == RD_INFO) || (state_q == RD_ID) || (state_q == RD_LO) ||
                       (state_q == RD_HI) || (state_q == CLEAR);

    always_comb begin
        state_d   = state_q;
        reg_req_o = '0;
        push      = 1'b0;
        if (in_access) begin
            reg_req_o.valid = 1'b1;
            reg_req_o.wstrb = 4'hF;
        end
        case (state_q)
            IDLE: begin
                // Holding off while full leaves the error latched in the IOPMP.
                if (wsi_i && (cnt_q != DEPTH_C)) state_d = RD_INFO;
            end
            RD_INFO: begin
                reg_req_o.addr = BASE_ADDR + OFF_ERR_INFO;
                if (reg_rsp_i.ready) begin
                    if (reg_rsp_i.error || !reg_rsp_i.rdata[0]) state_d = HOLD;
                    else                                         state_d = RD_ID;
                end
            end
            RD_ID: begin
                reg_req_o.addr = BASE_ADDR + OFF_ERR_REQID;
                if (reg_rsp_i.ready) state_d = reg_rsp_i.error ? HOLD : RD_LO;
            end
            RD_LO: begin
                reg_req_o.addr = BASE_ADDR + OFF_ERR_REQADDR;
                if (reg_rsp_i.ready) state_d = reg_rsp_i.error ? HOLD : RD_HI;
            end
            RD_HI: begin
                reg_req_o.addr = BASE_ADDR + OFF_ERR_REQADDR + 32'h4;
                if (reg_rsp_i.ready) state_d = reg_rsp_i.error ? HOLD : CLEAR;
            end
            CLEAR: begin
                reg_req_o.addr  = BASE_ADDR + OFF_ERR_INFO;
                reg_req_o.write = 1'b1;
                reg_req_o.wdata = 32'h1;
                if (reg_rsp_i.ready) begin
                    push    = !reg_rsp_i.error;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            info_q    <= '0;
            id_q      <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            drop_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= (state_q == HOLD) ? hold_q + 1'b1 : '0;
            if (reg_rsp_i.ready) begin
                case (state_q)
                    RD_INFO: info_q <= reg_rsp_i.rdata;
                    RD_ID:   id_q   <= reg_rsp_i.rdata;
                    RD_LO:   lo_q   <= reg_rsp_i.rdata;
                    RD_HI:   hi_q   <= reg_rsp_i.rdata;
                    default: ;
                endcase
            end
            if (in_access && reg_rsp_i.ready && reg_rsp_i.error) bus_err_q <= 1'b1;
            if ((state_q == RD_INFO) && reg_rsp_i.ready && !reg_rsp_i.error &&
                !reg_rsp_i.rdata[0] && (drop_q != 16'hFFFF))
                drop_q <= drop_q + 1'b1;
        end
    end

`ifdef RV_IOPMP_ERR_READER_TIMESTAMP_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ts_cnt_q   <= '0;
            ts_stage_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            if ((state_q == IDLE) && (state_d == RD_INFO)) ts_stage_q <= ts_cnt_q;
        end
    end
`endif

    // First-word fall-through record queue; entry to RD_INFO guarantees a free slot.
    assign rec_valid_o = (cnt_q != '0);
    assign pop         = rec_valid_o && rec_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push) mem[wr_q] <= rec_d;
    end

    assign head        = rec_valid_o ? mem[rd_q] : '0;
    assign rec_info_o  = head[127:96];
    assign rec_reqid_o = head[95:64];
    assign rec_addr_o  = head[63:0];
`ifdef RV_IOPMP_ERR_READER_TIMESTAMP_EN
    assign rec_ts_o    = head[159:128];
`endif
    assign bus_err_o   = bus_err_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_rv_iopmp_err_reader.sv
// Bench for rv_iopmp_err_reader: vector table, corner sequences and a randomized run against a register-file model.
module tb_rv_iopmp_err_reader;
    import rv_iopmp_err_reader_pkg::*;

    localparam int HOLDOFF = 2;
    localparam int DEPTH   = 4;

    typedef struct packed {
        logic [31:0] info;
        logic [31:0] id;
        logic [63:0] addr;
    } rec_t;

    typedef struct {
        logic [31:0] info, id, lo, hi;
        bit          spur;
        int          widx, wn, eidx;
        int          lat, ntr;
        int          drop;
        bit          berr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wsi, force_wsi;
    reg_req_t    req;
    reg_rsp_t    rsp;
    logic        rec_valid, rec_ready;
    logic [31:0] rec_info, rec_id;
    logic [63:0] rec_addr;
    logic        bus_err;
    logic [15:0] drop;
`ifdef RV_IOPMP_ERR_READER_TIMESTAMP_EN
    logic [31:0] rec_ts;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    // IOPMP error register model: a queue of pending errors, head is what ERR_* show.
    logic [31:0] e_info [256], e_id [256], e_lo [256], e_hi [256];
    logic [7:0]  e_head, e_tail;
    int          wcnt, wtarget, wait_idx, wait_n, err_idx;
    bit          rand_wait;
    rec_t        exp_q[$];
    int          tr_cnt, cyc;
    int          tr_cyc [256];

    always #5 clk = ~clk;

    assign wsi = force_wsi | (e_head != e_tail);

    rv_iopmp_err_reader #(.FIFO_DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wsi_i(wsi),
        .reg_req_o(req), .reg_rsp_i(rsp),
        .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
        .rec_info_o(rec_info), .rec_reqid_o(rec_id), .rec_addr_o(rec_addr),
`ifdef RV_IOPMP_ERR_READER_TIMESTAMP_EN
        .rec_ts_o(rec_ts),
`endif
        .bus_err_o(bus_err), .drop_cnt_o(drop)
    );

    function automatic int dec(input reg_req_t r);
        if (r.write) return 4;
        case (r.addr)
            32'h60:  return 0;
            32'h64:  return 1;
            32'h68:  return 2;
            32'h6C:  return 3;
            default: return 7;
        endcase
    endfunction

    always_comb begin
        int idx, tgt;
        rsp = '0;
        idx = dec(req);
        tgt = 0;
        if (req.valid) begin
            tgt       = rand_wait ? wtarget : ((idx == wait_idx) ? wait_n : 0);
            rsp.ready = (wcnt >= tgt);
            rsp.error = rsp.ready && (idx == err_idx);
            if (e_head != e_tail) begin
                case (idx)
                    0: rsp.rdata = e_info[e_head];
                    1: rsp.rdata = e_id[e_head];
                    2: rsp.rdata = e_lo[e_head];
                    3: rsp.rdata = e_hi[e_head];
                    default: rsp.rdata = 32'h0;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Bus monitor and record scoreboard; expected access order follows the service rules.
    initial begin : mon
        logic        pv, pacc, prv, prr, acc, sv, inrst, killp, clrp;
        logic [31:0] paddr, ea;
        logic [127:0] prec;
        int          nxt;
        rec_t        e;
        pv = 0; pacc = 0; prv = 0; prr = 0; paddr = 0; prec = 0; nxt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            acc = 0; killp = 0; clrp = 0; sv = req.valid; inrst = !rst_n;
            if (inrst) begin
                pv = 0; prv = 0; nxt = 0;
            end else begin
                if (pv && !pacc) chk("req_held", {req.valid, req.addr}, {1'b1, paddr});
                if (prv && !prr) chk("rec_held", {rec_valid, rec_info, rec_id, rec_addr}, {1'b1, prec});
                acc = req.valid && rsp.ready;
                if (acc) begin
                    ea = (nxt == 4) ? 32'h60 : 32'h60 + 32'(4 * nxt);
                    chk("req_fields", {req.addr, req.write, req.wstrb, req.write ? req.wdata : 32'h0},
                        {ea, nxt == 4, 4'hF, (nxt == 4) ? 32'h1 : 32'h0});
                    if (tr_cnt < 256) tr_cyc[tr_cnt] = cyc;
                    tr_cnt++;
                    if (rsp.error) begin nxt = 0; killp = 1; end
                    else if (nxt == 0 && !rsp.rdata[0]) nxt = 0;
                    else if (nxt == 4) begin nxt = 0; clrp = 1; end
                    else nxt++;
                end
                if (rec_valid && rec_ready) begin
                    if (exp_q.size() == 0) chk("rec_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rec_data", {rec_info, rec_id, rec_addr}, {e.info, e.id, e.addr});
                    end
                end
                pv = req.valid; pacc = acc; paddr = req.addr;
                prv = rec_valid; prr = rec_ready; prec = {rec_info, rec_id, rec_addr};
            end
            @(posedge clk); #1;
            if (inrst) wcnt = 0;
            else if (acc) begin
                wcnt    = 0;
                wtarget = $urandom_range(0, 3);
                // A bus-errored error is withdrawn so each vector sees a single service.
                if (clrp || killp) e_head++;
            end else if (sv) wcnt++;
        end
    end

    task automatic inject(input logic [31:0] info, id, lo, hi, input bit expect_rec);
        rec_t r;
        e_info[e_tail] = info; e_id[e_tail] = id; e_lo[e_tail] = lo; e_hi[e_tail] = hi;
        e_tail++;
        if (expect_rec) begin
            r.info = info; r.id = id; r.addr = {hi, lo};
            exp_q.push_back(r);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; force_wsi = 0; rand_wait = 0; wait_idx = -1; wait_n = 0; err_idx = -1;
        rec_ready = 0; e_head = 0; e_tail = 0; exp_q.delete();
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_req", req, '0);
        chk("rst_rec_valid", rec_valid, 0);
        chk("rst_rec_data", {rec_info, rec_id, rec_addr}, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_drop", drop, 0);
        tr_cnt = 0;
        rst_n  = 1;
    endtask

    function automatic vec_t mkv(logic [31:0] info, id, lo, hi, bit spur, int widx, wn, eidx,
                                 int lat, ntr, drp, bit berr);
        vec_t v;
        v.info = info; v.id = id; v.lo = lo; v.hi = hi; v.spur = spur;
        v.widx = widx; v.wn = wn; v.eidx = eidx; v.lat = lat; v.ntr = ntr; v.drop = drp; v.berr = berr;
        return v;
    endfunction

    initial begin : watchdog
        #(10 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t tv [7];
        int   first, injected;
        bit   found;
        logic [31:0] r;

        tv[0] = mkv(32'h5,         32'h1,         32'h8000_1000, 32'h0,         0, -1, 0, -1, 6, 5, 0, 0);
        tv[1] = mkv(32'h5,         32'h1,         32'h8000_1000, 32'h0,         0,  1, 3, -1, 9, 5, 0, 0);
        tv[2] = mkv(32'h0,         32'h0,         32'h0,         32'h0,         1, -1, 0, -1, 0, 1, 1, 0);
        tv[3] = mkv(32'hA5A5_0003, 32'h2,         32'h1234_5678, 32'hDEAD_BEEF, 0, -1, 0,  2, 0, 3, 0, 1);
        tv[4] = mkv(32'h0000_0101, 32'h77,        32'hFFFF_FFFC, 32'h1,         0,  4, 2, -1, 8, 5, 0, 0);
        tv[5] = mkv(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 0,  0, 1, -1, 7, 5, 0, 0);
        tv[6] = mkv(32'h9,         32'h3,         32'h40,        32'h0,         0, -1, 0,  0, 0, 1, 0, 1);

        wcnt = 0; wtarget = 0; cyc = 0; tr_cnt = 0;
        rst_n = 0; force_wsi = 0; rec_ready = 0; e_head = 0; e_tail = 0;
        rand_wait = 0; wait_idx = -1; wait_n = 0; err_idx = -1;

        for (int i = 0; i < 7; i++) begin
            do_reset();
            wait_idx = tv[i].widx; wait_n = tv[i].wn; err_idx = tv[i].eidx;
            if (tv[i].spur) force_wsi = 1;
            else inject(tv[i].info, tv[i].id, tv[i].lo, tv[i].hi, tv[i].lat != 0);
            first = 0;
            for (int n = 1; n <= 24; n++) begin
                @(posedge clk); #1;
                if (n == 1) force_wsi = 0;
                if (first == 0 && rec_valid) first = n;
            end
            chk($sformatf("v%0d_latency", i), first, tv[i].lat);
            chk($sformatf("v%0d_transactions", i), tr_cnt, tv[i].ntr);
            chk($sformatf("v%0d_drop", i), drop, tv[i].drop);
            chk($sformatf("v%0d_bus_err", i), bus_err, tv[i].berr);
            chk($sformatf("v%0d_pending", i), e_tail - e_head, 0);
            rec_ready = 1;
            @(posedge clk); #1;
            rec_ready = 0;
            chk($sformatf("v%0d_rec_left", i), exp_q.size(), 0);
        end

        // Full FIFO with wsi held high, then one pop lets a fifth service run.
        do_reset();
        for (int k = 0; k < 5; k++) inject(32'h11 + 32'(k << 4), 32'(100 + k), 32'h1000 * k, 32'(k), 1);
        repeat (60) begin @(posedge clk); #1; end
        chk("full_transactions", tr_cnt, 4 * 5);
        chk("full_clears", e_head, 4);
        chk("full_rec_valid", rec_valid, 1);
        chk("holdoff_gap", tr_cyc[5] - tr_cyc[4], 2 + HOLDOFF);
        rec_ready = 1;
        @(posedge clk); #1;
        rec_ready = 0;
        repeat (20) begin @(posedge clk); #1; end
        chk("fifth_transactions", tr_cnt, 5 * 5);
        chk("fifth_clears", e_head, 5);
        rec_ready = 1;
        repeat (10) begin @(posedge clk); #1; end
        rec_ready = 0;
        chk("full_drained", exp_q.size(), 0);

        // Reset during RD_HI: access dropped, error left pending and re-serviced.
        do_reset();
        wait_idx = 3; wait_n = 6;
        inject(32'h21, 32'h5, 32'hC000_0000, 32'h2, 1);
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(posedge clk); #1;
            if (req.valid && req.addr == 32'h6C) found = 1;
        end
        chk("rd_hi_reached", found, 1);
        rst_n = 0;
        @(posedge clk); #1;
        chk("midrst_valid", req.valid, 0);
        chk("midrst_rec_valid", rec_valid, 0);
        chk("midrst_flags", {bus_err, drop}, 0);
        chk("midrst_pending", e_tail - e_head, 1);
        rst_n = 1; wait_idx = -1; rec_ready = 1;
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin @(posedge clk); #1; end
        rec_ready = 0;
        chk("midrst_reserviced", exp_q.size(), 0);
        chk("midrst_transactions", tr_cnt, 3 + 5);

        // Randomized: every injected error must come out once, in order, with no drops.
        do_reset();
        rand_wait = 1;
        injected  = 0;
        for (int c = 0; c < 8000 && !(injected == 40 && exp_q.size() == 0); c++) begin
            @(posedge clk); #1;
            rec_ready = 1'($urandom_range(0, 1));
            if (injected < 40 && $urandom_range(0, 7) == 0) begin
                r = $urandom;
                inject({r[31:1], 1'b1}, $urandom, $urandom, $urandom, 1);
                injected++;
            end
        end
        rec_ready = 0;
        repeat (8) begin @(posedge clk); #1; end
        chk("rand_injected", injected, 40);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_pending", e_tail - e_head, 0);
        chk("rand_transactions", tr_cnt, 40 * 5);
        chk("rand_flags", {bus_err, drop}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
